// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (a..g in bits 6..0), BCD codes
// and the scan decoder's frame-assembly states.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam bcd_t BCD_BLANK   = 4'hF;
    localparam bcd_t BCD_INVALID = 4'hE;

    typedef enum logic {
        ST_COLLECT  = 1'b0,
        ST_COMPLETE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder; unknown patterns
// decode to BCD_INVALID with err raised, an all-dark digit decodes to BCD_BLANK.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scrapes a multiplexed 7-segment bus: debounces each digit dwell, decodes it
// and hands complete frames to a valid/ready consumer.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_COLLECT  | capturing digits, capture mask not yet full
// ST_COMPLETE | one cycle: load frame into output slot or drop it (overrun)
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  frame_err,
    output logic                  overrun
);

    seg_t                seg_s, seg_p;
    logic [DIGITS-1:0]   an_s, an_p;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   mask, errbits;
    scan_state_t         state, state_next;

    bcd_t                dec_bcd;
    logic                dec_err;
    logic                same, cap, complete, slot_free;
    logic [DIGITS-1:0]   cap_bits, mask_base, err_base;

    seg7_decode u_decode (
        .seg (seg_s),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // A dwell only counts while the select is a legal one-hot code.
    always_comb begin
        same      = $onehot(an_s) && (seg_s == seg_p) && (an_s == an_p);
        cap       = same && (cnt == CNT_W'(STABLE_CYCLES - 2));
        cap_bits  = cap ? an_s : '0;
        slot_free = !frame_valid || frame_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            ST_COLLECT: begin
                if ((mask | cap_bits) == '1) state_next = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                complete   = 1'b1;
                state_next = ST_COLLECT;
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Completion clears the mask; a capture landing on that same cycle is kept.
    always_comb begin
        mask_base = complete ? '0 : mask;
        err_base  = complete ? '0 : errbits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s       <= '0;
            seg_p       <= '0;
            an_s        <= '0;
            an_p        <= '0;
            cnt         <= '0;
            shadow      <= '0;
            mask        <= '0;
            errbits     <= '0;
            frame_valid <= 1'b0;
            digits_out  <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            seg_s <= seg_in;
            an_s  <= an_in;
            seg_p <= seg_s;
            an_p  <= an_s;

            if (!same)                                cnt <= '0;
            else if (cnt != CNT_W'(STABLE_CYCLES))    cnt <= cnt + 1'b1;

            for (int i = 0; i < DIGITS; i++) begin
                if (cap_bits[i]) shadow[4*i +: 4] <= dec_bcd;
            end
            mask    <= mask_base | cap_bits;
            errbits <= (err_base & ~cap_bits) | (cap_bits & {DIGITS{dec_err}});

            if (complete && slot_free) begin
                digits_out  <= shadow;
                frame_err   <= |errbits;
                frame_valid <= 1'b1;
            end else begin
                if (complete)                   overrun     <= 1'b1;
                if (frame_valid && frame_ready) frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int S      = 8;

    localparam logic [6:0] PATS [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] digits_out;
    logic        frame_err;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg),
        .an_in       (an),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .digits_out  (digits_out),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: count identical one-hot samples; the S-th one captures,
    // a full set of digits becomes visible two clocks after its last capture.
    int          run;
    logic [6:0]  prev_seg;
    logic [3:0]  prev_an;
    bit          prev_ok;
    logic [15:0] m_shadow;
    logic [3:0]  m_mask, m_errs;
    int          pend;
    logic [15:0] pend_digits;
    logic        pend_err;
    logic        exp_valid, exp_err, exp_ovr;
    logic [15:0] exp_digits;

    function automatic logic [4:0] mdecode(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (s == PATS[i]) return {1'b0, 4'(i)};
        if (s == 7'd0) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            run = 0; prev_ok = 0; prev_seg = '0; prev_an = '0;
            m_shadow = '0; m_mask = '0; m_errs = '0; pend = 0;
            exp_valid = 0; exp_err = 0; exp_ovr = 0; exp_digits = '0;
        end else begin
            if (pend == 1) begin
                if (!exp_valid || frame_ready) begin
                    exp_valid = 1; exp_digits = pend_digits; exp_err = pend_err;
                end else begin
                    exp_ovr = 1;
                end
            end else if (exp_valid && frame_ready) begin
                exp_valid = 0;
            end
            if (pend > 0) pend--;

            if ($onehot(an) && prev_ok && seg == prev_seg && an == prev_an) run++;
            else run = $onehot(an) ? 1 : 0;
            prev_seg = seg; prev_an = an; prev_ok = $onehot(an);

            if (run == S) begin
                logic [4:0] dec;
                int d;
                d = 0;
                for (int i = 0; i < DIGITS; i++) if (an[i]) d = i;
                dec = mdecode(seg);
                m_shadow[4*d +: 4] = dec[3:0];
                m_mask[d] = 1'b1;
                m_errs[d] = dec[4];
                if (&m_mask) begin
                    pend = 2; pend_digits = m_shadow; pend_err = |m_errs;
                    m_mask = '0; m_errs = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (frame_valid !== exp_valid || overrun !== exp_ovr) begin
                fails++;
                $display("FAIL cycle_ctrl @%0t: got valid=%b ovr=%b, want valid=%b ovr=%b",
                         $time, frame_valid, overrun, exp_valid, exp_ovr);
            end
            if (exp_valid) begin
                tests++;
                if (digits_out !== exp_digits || frame_err !== exp_err) begin
                    fails++;
                    $display("FAIL cycle_data @%0t: got digits=%h err=%b, want digits=%h err=%b",
                             $time, digits_out, frame_err, exp_digits, exp_err);
                end
            end
        end
    end

    // Frames actually accepted by the consumer (handshake on the coming edge).
    int          acc_count = 0;
    logic [15:0] last_acc  = '0;
    logic        last_err  = 1'b0;
    always @(negedge clk) begin
        if (!rst && frame_valid === 1'b1 && frame_ready) begin
            acc_count++;
            last_acc = digits_out;
            last_err = frame_err;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dwell(input int d, input logic [6:0] s, input int n);
        an  = 4'b0001 << d;
        seg = s;
        step(n);
    endtask

    task automatic idle(input int n);
        an  = '0;
        seg = '0;
        step(n);
    endtask

    int n0;

    initial begin
        rst = 1'b1; seg = '0; an = '0; frame_ready = 1'b1;
        step(1);
        started = 1;
        step(2);
        check("reset_valid", 16'(frame_valid), 16'h0);
        check("reset_digits", digits_out, 16'h0);
        check("reset_ovr", 16'(overrun), 16'h0);
        rst = 1'b0;
        idle(2);

        // Basic scan 1,2,3,4
        n0 = acc_count;
        dwell(0, PATS[1], 10); dwell(1, PATS[2], 10);
        dwell(2, PATS[3], 10); dwell(3, PATS[4], 10);
        idle(4);
        check("t1_count", 16'(acc_count - n0), 16'd1);
        check("t1_digits", last_acc, 16'h4321);
        check("t1_err", 16'(last_err), 16'h0);
        check("t1_model", exp_digits, 16'h4321);

        // Short glitch on digit 2 must not be captured
        n0 = acc_count;
        dwell(0, PATS[7], 10); dwell(1, PATS[7], 10);
        dwell(2, PATS[1], 5);  dwell(2, PATS[8], 10);
        dwell(3, PATS[7], 10);
        idle(4);
        check("t2_count", 16'(acc_count - n0), 16'd1);
        check("t2_digits", last_acc, 16'h7877);

        // Illegal and blank digits
        n0 = acc_count;
        dwell(0, 7'b1000000, 10); dwell(1, 7'b0000000, 10);
        dwell(2, PATS[7], 10);    dwell(3, PATS[7], 10);
        idle(4);
        check("t3_count", 16'(acc_count - n0), 16'd1);
        check("t3_digits", last_acc, 16'h77FE);
        check("t3_err", 16'(last_err), 16'h1);
        check("t3_model_err", 16'(exp_err), 16'h1);

        // Backpressure: second frame dropped
        frame_ready = 1'b0;
        n0 = acc_count;
        dwell(0, PATS[1], 10); dwell(1, PATS[2], 10);
        dwell(2, PATS[3], 10); dwell(3, PATS[4], 10);
        idle(3);
        check("t4_held_a", digits_out, 16'h4321);
        dwell(0, PATS[5], 10); dwell(1, PATS[6], 10);
        dwell(2, PATS[7], 10); dwell(3, PATS[8], 10);
        idle(4);
        check("t4_valid", 16'(frame_valid), 16'h1);
        check("t4_held_b", digits_out, 16'h4321);
        check("t4_ovr", 16'(overrun), 16'h1);
        check("t4_model_ovr", 16'(exp_ovr), 16'h1);
        check("t4_no_acc", 16'(acc_count - n0), 16'd0);
        frame_ready = 1'b1;
        step(1);
        check("t4_drop_valid", 16'(frame_valid), 16'h0);
        check("t4_ovr_sticky", 16'(overrun), 16'h1);
        check("t4_acc", 16'(acc_count - n0), 16'd1);
        check("t4_acc_digits", last_acc, 16'h4321);

        // Illegal selects never capture
        n0 = acc_count;
        an = 4'b0000; seg = PATS[8]; step(20);
        an = 4'b0011; step(20);
        idle(4);
        check("t5_valid", 16'(frame_valid), 16'h0);
        check("t5_count", 16'(acc_count - n0), 16'd0);

        // Reset mid-frame discards partial captures
        dwell(0, PATS[9], 10); dwell(1, PATS[9], 10); dwell(2, PATS[9], 10);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        n0 = acc_count;
        dwell(0, PATS[0], 10); dwell(1, PATS[5], 10);
        dwell(2, PATS[6], 10); dwell(3, PATS[9], 10);
        idle(6);
        check("t6_count", 16'(acc_count - n0), 16'd1);
        check("t6_digits", last_acc, 16'h9650);
        check("t6_ovr_cleared", 16'(overrun), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment encoder.
- Observes a time-multiplexed 7-segment display bus (segment lines plus one-hot digit select), debounces each digit dwell and decodes segment patterns back to BCD.
- Assembles complete multi-digit frames and presents them through a valid/ready handshake.
- Used for display loop-back checking and for scraping legacy display panels.

Parameters:
- DIGITS, 4, number of multiplexed digits; one-hot select width.
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is captured (min 2).
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines, active-high; bit6=a, bit5=b … bit0=g.
- an_in  input  DIGITS  digit select, one-hot, active-high; bit i selects digit i.
- frame_valid  output  1  frame available on digits_out.
- frame_ready  input  1  consumer accepts frame when high with frame_valid.
- digits_out  output  4*DIGITS  digit i in bits [4i+3:4i].
- frame_err  output  1  at least one digit in the presented frame was an illegal pattern.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: frame_valid=0, digits_out=0, frame_err=0, overrun=0. Internal state is also cleared: capture mask, shadow digits, counter, sample registers.
- Input sampling: seg_in and an_in are registered once (sample stage).
- Stability counter, per cycle:
  - If the sample differs from the previous sample, or an_in is not one-hot (zero or multiple bits), cnt := 0 and the dwell is re-armed.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Capture: fires on the single cycle cnt reaches STABLE_CYCLES-1, i.e. after STABLE_CYCLES identical one-hot samples.
  - The decoded digit is written to shadow[idx], and mask[idx] and errbit[idx] are set.
  - Only one capture per dwell.
  - Re-capture of an already-captured index within the same frame overwrites that shadow entry.
- Decode, combinational:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000→4'hF (blank), no error.
  - Any other pattern→4'hE with errbit set.
- Frame completion: the cycle after mask becomes all-ones.
  - If the output slot is free (frame_valid=0, or frame_valid&frame_ready this cycle), load digits_out and frame_err (OR of errbits), then set frame_valid.
  - Otherwise drop the frame and set overrun.
  - In either case clear mask and errbits.
- Handshake:
  - frame_valid stays high and digits_out/frame_err stay stable until frame_valid&frame_ready.
  - On handshake, frame_valid drops next cycle unless a new frame loads on that same cycle, in which case it stays high with new data.
- Latency: last digit's STABLE_CYCLES-th sample → frame_valid high 2 clocks later (capture + completion).
- overrun clears only on rst.
- Reset mid-dwell or mid-frame: all partial progress is discarded; the next frame needs all DIGITS captures anew.
- Digit order on the bus is arbitrary; scan rate is irrelevant as long as each dwell ≥ STABLE_CYCLES+1 clocks.

States (explicit FSM):
- COLLECT: mask not full.
- COMPLETE: one cycle; load or drop.
- COMPLETE always returns to COLLECT.
- The output slot is tracked independently by frame_valid.

Decomposition:
- Package seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants, shared with the encoder.
  - BCD_BLANK=4'hF and BCD_INVALID=4'hE.
  - seg_t (7-bit) and bcd_t (4-bit) typedefs.
- Sub-module seg7_decode: combinational seg_t→{bcd_t, err}, instantiated once on the sample stage.

Test Plan:
- Reset, DIGITS=4, STABLE_CYCLES=8; scan digits 0..3 showing 1,2,3,4, 10 clocks each, frame_ready=1 → frame_valid pulses; digits_out=16'h4321, frame_err=0.
- Glitch dwell: digit 2 shows 0110000 for 5 clocks, then 1111111 for 10 → digit 2 captured as 8. The 5-clock glitch is never captured.
- Illegal and blank: digit 0 shows 1000000, digit 1 shows 0000000, others 7 → digits_out=16'h77FE, frame_err=1.
- Backpressure: frame_ready=0 across two full frames → first frame held stable, second dropped, overrun=1. Raising frame_ready clears frame_valid next cycle; overrun stays 1.
- Bad select: an_in=4'b0000 or 4'b0011 held 20 clocks → no capture, no frame_valid.
- Reset mid-frame: assert rst after 3 digits captured, then scan 4 digits → exactly one frame, containing only the post-reset values.
